// File: rtl/tc_timer_pkg.sv
// Shared definitions for the tc_timer countdown timer: register map, CTRL fields,
// MODE codes and FSM state encodings.
package tc_timer_pkg;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] AddrRsvd   = 2'd3;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlImBit   = 3;

    localparam logic [1:0] ModeOneShot = 2'd0;
    localparam logic [1:0] ModeReload  = 2'd1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped programmable countdown timer with one-shot and auto-reload modes
// and a maskable registered interrupt.
module tc_timer
    import tc_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq
);

    tc_state_e        r_state;
    tc_state_e        w_state_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_im;
    logic             w_im_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] w_preset_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_reload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_en     <= 1'b0;
            r_mode   <= 2'd0;
            r_im     <= 1'b0;
            r_pend   <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_en     <= w_en_nxt;
            r_mode   <= w_mode_nxt;
            r_im     <= w_im_nxt;
            r_pend   <= w_pend_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_wr_ctrl    = write_enable && (addr == AddrCtrl);
        w_wr_preset  = write_enable && (addr == AddrPreset);
        w_reload     = (r_mode == ModeReload);
        w_state_nxt  = r_state;
        w_en_nxt     = r_en;
        w_mode_nxt   = r_mode;
        w_im_nxt     = r_im;
        w_pend_nxt   = r_pend;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;

        // A register write suppresses every FSM action of this cycle, COUNT included.
        if (w_wr_ctrl || w_wr_preset) begin
            w_state_nxt = StIdle;
            w_pend_nxt  = 1'b0;
            if (w_wr_ctrl) begin
                w_en_nxt   = write_data[CtrlEnBit];
                w_mode_nxt = write_data[CtrlModeLsb +: 2];
                w_im_nxt   = write_data[CtrlImBit];
            end
            if (w_wr_preset) begin
                w_preset_nxt = write_data[WIDTH-1:0];
            end
        end else begin
            // Auto-reload PEND lives for exactly the one cycle after INT.
            if (w_reload) begin
                w_pend_nxt = 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (r_en) begin
                        w_state_nxt = StLoad;
                    end
                end
                StLoad: begin
                    w_count_nxt = r_preset;
                    w_state_nxt = StCnt;
                end
                StCnt: begin
                    if (!r_en) begin
                        w_state_nxt = StIdle;
                    end else if (r_count == '0) begin
                        w_state_nxt = StInt;
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
                StInt: begin
                    w_pend_nxt = 1'b1;
                    if (w_reload) begin
                        w_state_nxt = StLoad;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_comb begin
        read_result = '0;
        case (addr)
            AddrCtrl:   read_result = {28'd0, r_im, r_mode, r_en};
            AddrPreset: read_result = 32'(r_preset);
            AddrCount:  read_result = 32'(r_count);
            default:    read_result = '0;
        endcase
    end

    assign irq = r_pend & r_im;

endmodule

// File: tb/tb_tc_timer.sv
// Directed scoreboard bench for tc_timer: expectations are queued as stimulus is
// applied and popped as the DUT outputs are sampled one time unit after each edge.
module tb_tc_timer;
    import tc_timer_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_result;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_err    = 0;

    tc_timer #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_result  (read_result),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h required=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a;
        #1;
        chk(read_result);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        push(tag, exp);
        rd(a);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        push(tag, {31'd0, exp});
        chk({31'd0, irq});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        int ph;
        rst          = 1'b0;
        addr         = AddrCtrl;
        write_enable = 1'b1;
        write_data   = 32'hFFFF_FFFF;

        // Reset held with a write strobe active
        tick(3);
        rd_chk("rst_ctrl", AddrCtrl, 32'd0);
        rd_chk("rst_preset", AddrPreset, 32'd0);
        rd_chk("rst_count", AddrCount, 32'd0);
        rd_chk("rst_rsvd", AddrRsvd, 32'd0);
        irq_chk("rst_irq", 1'b0);
        write_enable = 1'b0;
        rst          = 1'b1;
        tick(1);
        rd_chk("rel_ctrl", AddrCtrl, 32'd0);
        irq_chk("rel_irq", 1'b0);

        // One-shot, P=5: irq rises after E9 and holds
        wr(AddrPreset, 32'd5);
        wr(AddrCtrl, 32'h9);
        tick(8);
        irq_chk("os_irq_e8", 1'b0);
        tick(1);
        irq_chk("os_irq_e9", 1'b1);
        rd_chk("os_ctrl", AddrCtrl, 32'h8);
        rd_chk("os_count", AddrCount, 32'd0);
        tick(3);
        irq_chk("os_irq_hold", 1'b1);
        wr(AddrCtrl, 32'h0);
        irq_chk("os_irq_drop", 1'b0);

        // Auto-reload, P=2: period 5, pulses after E6, E11, E16, E21
        wr(AddrPreset, 32'd2);
        wr(AddrCtrl, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            push($sformatf("ar_irq_e%0d", k), (k >= 6 && (k - 6) % 5 == 0) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                ph = (k - 2) % 5;
                push($sformatf("ar_count_e%0d", k), (ph <= 2) ? 32'(2 - ph) : 32'd0);
            end
        end
        for (int k = 1; k <= 22; k++) begin
            tick(1);
            chk({31'd0, irq});
            if (k >= 2) rd(AddrCount);
        end

        // Masked auto-reload, P=3: no irq, COUNT still cycles with period 6
        wr(AddrPreset, 32'd3);
        wr(AddrCtrl, 32'h3);
        for (int k = 1; k <= 20; k++) begin
            push($sformatf("mask_irq_e%0d", k), 32'd0);
            if (k >= 2) begin
                ph = (k - 2) % 6;
                push($sformatf("mask_count_e%0d", k), (ph <= 3) ? 32'(3 - ph) : 32'd0);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk({31'd0, irq});
            if (k >= 2) rd(AddrCount);
        end

        // Pause mid-count then restart from a full reload
        wr(AddrCtrl, 32'h0);
        wr(AddrPreset, 32'd10);
        wr(AddrCtrl, 32'h9);
        tick(6);
        rd_chk("pause_count_pre", AddrCount, 32'd6);
        wr(AddrCtrl, 32'h0);
        rd_chk("pause_count_frozen", AddrCount, 32'd6);
        tick(15);
        rd_chk("pause_count_later", AddrCount, 32'd6);
        irq_chk("pause_irq", 1'b0);
        wr(AddrCtrl, 32'h9);
        tick(2);
        rd_chk("restart_count_e2", AddrCount, 32'd10);
        tick(10);
        rd_chk("restart_count_e12", AddrCount, 32'd0);
        irq_chk("restart_irq_e12", 1'b0);
        tick(1);
        irq_chk("restart_irq_e13", 1'b0);
        tick(1);
        irq_chk("restart_irq_e14", 1'b1);
        rd_chk("restart_ctrl", AddrCtrl, 32'h8);

        // PRESET write on the exact edge that would enter INT
        wr(AddrCtrl, 32'h0);
        wr(AddrPreset, 32'd4);
        wr(AddrCtrl, 32'h9);
        tick(6);
        wr(AddrPreset, 32'd7);
        irq_chk("coll_irq_e7", 1'b0);
        rd_chk("coll_preset", AddrPreset, 32'd7);
        rd_chk("coll_count_e7", AddrCount, 32'd0);
        tick(1);
        irq_chk("coll_irq_e8", 1'b0);
        rd_chk("coll_count_e8", AddrCount, 32'd0);
        tick(1);
        rd_chk("coll_count_e9", AddrCount, 32'd7);
        wr(AddrCtrl, 32'h0);

        // Writes to COUNT and reserved offsets are ignored
        wr(AddrCount, 32'hFFFF_FFFF);
        wr(AddrRsvd, 32'hFFFF_FFFF);
        rd_chk("ro_ctrl", AddrCtrl, 32'h0);
        rd_chk("ro_preset", AddrPreset, 32'd7);
        rd_chk("ro_count", AddrCount, 32'd7);
        rd_chk("ro_rsvd", AddrRsvd, 32'd0);
        irq_chk("ro_irq", 1'b0);
        tick(3);
        rd_chk("ro_count_later", AddrCount, 32'd7);

        // Asynchronous reset mid-count
        wr(AddrPreset, 32'd20);
        wr(AddrCtrl, 32'hB);
        tick(5);
        rd_chk("mid_count_pre", AddrCount, 32'd17);
        rst = 1'b0;
        rd_chk("mid_count_rst", AddrCount, 32'd0);
        irq_chk("mid_irq_rst", 1'b0);
        rd_chk("mid_ctrl_rst", AddrCtrl, 32'd0);
        rd_chk("mid_preset_rst", AddrPreset, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(4);
        rd_chk("mid_count_after", AddrCount, 32'd0);

        // Asynchronous reset while a one-shot irq is held
        wr(AddrPreset, 32'd1);
        wr(AddrCtrl, 32'h9);
        tick(5);
        irq_chk("held_irq_pre", 1'b1);
        rst = 1'b0;
        #1;
        irq_chk("held_irq_rst", 1'b0);
        tick(1);
        rst = 1'b1;
        tick(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
